// File: rtl/sc_dmem_arbiter.sv
// Two-master round-robin arbiter with bounded locking in front of a single-port data memory.
// Optional contention counter is built only when DMEM_ARB_STATS_EN is defined.
module sc_dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic          m0_lock,
    input  logic          m1_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stat_conflicts
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

    function automatic logic [CW-1:0] lock_inc(input logic [CW-1:0] cnt);
        return (cnt < CNT_MAX) ? cnt + 1'b1 : CNT_MAX;
    endfunction

    logic          last;
    logic          owner;
    logic          locked;
    logic [CW-1:0] lock_cnt;
    logic          rv0;
    logic          rv1;
    logic          gnt0;
    logic          gnt1;
    logic          sel_lock;

    // last=1 means m1 was served last, so m0 wins the next tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (m0_req && m1_req) begin
            if (locked && (lock_cnt < CNT_MAX)) begin
                gnt0 = ~owner;
                gnt1 = owner;
            end else begin
                gnt0 = last;
                gnt1 = ~last;
            end
        end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
        end
    end

    assign sel_lock  = gnt1 ? m1_lock : m0_lock;
    assign mem_addr  = gnt1 ? m1_addr : m0_addr;
    assign mem_wdata = gnt1 ? m1_wdata : m0_wdata;
    assign mem_we    = (gnt0 & m0_we) | (gnt1 & m1_we);
    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last     <= 1'b1;
            owner    <= 1'b0;
            locked   <= 1'b0;
            lock_cnt <= '0;
            rv0      <= 1'b0;
            rv1      <= 1'b0;
        end else begin
            rv0 <= gnt0 & ~m0_we;
            rv1 <= gnt1 & ~m1_we;
            if (gnt0 || gnt1) begin
                last <= gnt1;
                if (sel_lock) begin
                    locked <= 1'b1;
                    owner  <= gnt1;
                    if (locked && (owner == gnt1))
                        lock_cnt <= lock_inc(lock_cnt);
                    else
                        lock_cnt <= CW'(1);
                end else begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                end
            end else begin
                // nobody requesting: any holder has dropped req and loses the lock
                locked   <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

    assign m0_rvalid = rv0;
    assign m1_rvalid = rv1;
    assign m0_rdata  = rv0 ? mem_rdata : '0;
    assign m1_rdata  = rv1 ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] conflicts;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            conflicts <= '0;
        else if (m0_req && m1_req)
            conflicts <= sat_inc16(conflicts);
    end

    assign stat_conflicts = conflicts;
`else
    assign stat_conflicts = 16'h0000;
`endif

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Bench for sc_dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the grant, lock and read-return rules.
module tb_sc_dmem_arbiter;

    localparam int ML = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0, m0_lock = 0, m1_lock = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] stat_conflicts;

    sc_dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(ML)) dut (
        .clock(clock), .resetn(resetn),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_lock(m0_lock), .m1_lock(m1_lock), .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .stat_conflicts(stat_conflicts)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0101;
    endfunction

    // Memory behind the arbiter: synchronous read, one cycle latency
    logic [31:0] tbmem [16];
    always @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) tbmem[i] <= init_word(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) tbmem[mem_addr[5:2]] <= mem_wdata;
            mem_rdata <= tbmem[mem_addr[5:2]];
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          mdl_last, mdl_owner, mdl_streak, mdl_stat;
    bit          mdl_locked, mdl_rv0, mdl_rv1;
    logic [31:0] mdl_rd0, mdl_rd1;
    logic [31:0] model_mem [16];

    // Per-cycle observations and expectations
    int          exp_g;
    logic        exp_we, exp_rv0, exp_rv1;
    logic [31:0] exp_addr, exp_rd0, exp_rd1;
    logic        obs_g0, obs_g1, obs_we, obs_rv0, obs_rv1;
    logic [31:0] obs_addr, obs_rd0, obs_rd1;
    logic [15:0] obs_stat;

    task automatic model_reset();
        mdl_last = 1; mdl_owner = 0; mdl_streak = 0; mdl_stat = 0;
        mdl_locked = 0; mdl_rv0 = 0; mdl_rv1 = 0; mdl_rd0 = 0; mdl_rd1 = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
    endtask

    // 0 = nobody, 1 = m0, 2 = m1
    function automatic int model_grant();
        if (!m0_req && !m1_req) return 0;
        if (m0_req != m1_req) return m0_req ? 1 : 2;
        if (mdl_locked && mdl_streak < ML) return mdl_owner + 1;
        return (mdl_last == 0) ? 2 : 1;
    endfunction

    function automatic int exp_stat();
`ifdef DMEM_ARB_STATS_EN
        return mdl_stat;
`else
        return 0;
`endif
    endfunction

    task automatic model_commit(input int g);
        int m;
        logic we, lk;
        logic [31:0] a, d;
        if (m0_req && m1_req && mdl_stat < 65535) mdl_stat++;
        mdl_rv0 = 0;
        mdl_rv1 = 0;
        if (g == 0) begin
            mdl_locked = 0;
            mdl_streak = 0;
        end else begin
            m  = g - 1;
            we = m ? m1_we : m0_we;
            lk = m ? m1_lock : m0_lock;
            a  = m ? m1_addr : m0_addr;
            d  = m ? m1_wdata : m0_wdata;
            if (lk) begin
                if (mdl_locked && mdl_owner == m)
                    mdl_streak = (mdl_streak < ML) ? mdl_streak + 1 : ML;
                else
                    mdl_streak = 1;
                mdl_locked = 1;
                mdl_owner  = m;
            end else begin
                mdl_locked = 0;
                mdl_streak = 0;
            end
            mdl_last = m;
            if (we) model_mem[a[5:2]] = d;
            else if (m == 0) begin mdl_rv0 = 1; mdl_rd0 = model_mem[a[5:2]]; end
            else begin mdl_rv1 = 1; mdl_rd1 = model_mem[a[5:2]]; end
        end
    endtask

    // One clock: sample at negedge, advance model at posedge, return #1 after it
    task automatic tick();
        @(negedge clock);
        exp_g    = model_grant();
        exp_we   = (exp_g == 1) ? m0_we : (exp_g == 2) ? m1_we : 1'b0;
        exp_addr = (exp_g == 2) ? m1_addr : m0_addr;
        exp_rv0  = mdl_rv0;
        exp_rv1  = mdl_rv1;
        exp_rd0  = mdl_rv0 ? mdl_rd0 : 32'h0;
        exp_rd1  = mdl_rv1 ? mdl_rd1 : 32'h0;
        obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_we = mem_we; obs_addr = mem_addr;
        obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid; obs_rd0 = m0_rdata; obs_rd1 = m1_rdata;
        obs_stat = stat_conflicts;
        @(posedge clock);
        model_commit(exp_g);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 0;
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_lock = 0; m1_lock = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        repeat (2) @(posedge clock);
        model_reset();
        #1 resetn = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b required 00000",
                               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we});
        end
        checks++;
        if (stat_conflicts !== 16'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: stat=%0h rd0=%0h rd1=%0h required 0",
                               stat_conflicts, m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_tie_reads();
        apply_reset();
        m0_req = 1; m0_addr = 32'h14; m1_req = 1; m1_addr = 32'h28;
        tick();
        checks++;
        if ({obs_g0, obs_g1} !== 2'b10) begin
            errors++; $display("FAIL tie_first: got g0g1=%b required 10", {obs_g0, obs_g1});
        end
        m0_req = 0;
        tick();
        checks++;
        if ({obs_g0, obs_g1} !== 2'b01) begin
            errors++; $display("FAIL tie_second: got g0g1=%b required 01", {obs_g0, obs_g1});
        end
        checks++;
        if (obs_rv0 !== 1'b1 || obs_rv1 !== 1'b0 || obs_rd0 !== init_word(5)) begin
            errors++; $display("FAIL tie_rdata0: rv0=%b rv1=%b rd0=%0h required 1 0 %0h",
                               obs_rv0, obs_rv1, obs_rd0, init_word(5));
        end
        m1_req = 0;
        tick();
        checks++;
        if (obs_rv1 !== 1'b1 || obs_rv0 !== 1'b0 || obs_rd1 !== init_word(10) || obs_rd0 !== 32'h0) begin
            errors++; $display("FAIL tie_rdata1: rv1=%b rv0=%b rd1=%0h rd0=%0h required 1 0 %0h 0",
                               obs_rv1, obs_rv0, obs_rd1, obs_rd0, init_word(10));
        end
    endtask

    task automatic test_m1_write();
        apply_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hA5A5_A5A5;
        tick();
        checks++;
        if (obs_g1 !== 1'b1 || obs_g0 !== 1'b0 || obs_we !== 1'b1 || obs_addr !== 32'h40) begin
            errors++; $display("FAIL m1_write: g1=%b g0=%b we=%b addr=%0h required 1 0 1 40",
                               obs_g1, obs_g0, obs_we, obs_addr);
        end
        m1_req = 0; m1_we = 0;
        tick();
        checks++;
        if (obs_rv1 !== 1'b0 || obs_rv0 !== 1'b0) begin
            errors++; $display("FAIL write_no_rvalid: rv1=%b rv0=%b required 0 0", obs_rv1, obs_rv0);
        end
    endtask

    task automatic test_lock();
        logic e0;
        apply_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h20;
        for (int k = 0; k < 3 * (ML + 1); k++) begin
            tick();
            e0 = ((k % (ML + 1)) < ML);
            checks++;
            if (obs_g0 !== e0 || obs_g1 !== !e0) begin
                errors++; $display("FAIL lock_seq[%0d]: got g0g1=%b%b required %b%b",
                                   k, obs_g0, obs_g1, e0, !e0);
            end
        end
    endtask

    task automatic test_lock_drop();
        int  run;
        bit  done;
        apply_reset();
        m0_req = 1; m0_lock = 1; m1_req = 1;
        repeat (3) tick();
        m0_req = 0;
        tick();
        checks++;
        if ({obs_g0, obs_g1} !== 2'b01) begin
            errors++; $display("FAIL drop_handoff: got g0g1=%b required 01", {obs_g0, obs_g1});
        end
        m0_req = 1;
        run = 0; done = 0;
        for (int i = 0; i < ML + 4; i++) begin
            tick();
            if (!done) begin
                if (obs_g0) run++;
                else done = 1;
            end
        end
        checks++;
        if (run != ML || !done) begin
            errors++; $display("FAIL drop_restart: got run=%0d ended=%0d required %0d 1", run, done, ML);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m0_req = 1; m0_addr = 32'h8;
        tick();
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== init_word(2)) begin
            errors++; $display("FAIL mid_rvalid_pre: rv0=%b rd0=%0h required 1 %0h",
                               m0_rvalid, m0_rdata, init_word(2));
        end
        resetn = 0;
        #1;
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
            errors++; $display("FAIL mid_rvalid_clear: rv0=%b rd0=%0h required 0 0", m0_rvalid, m0_rdata);
        end
        apply_reset();
        m0_req = 1; m1_req = 1;
        tick();
        checks++;
        if ({obs_g0, obs_g1} !== 2'b10) begin
            errors++; $display("FAIL mid_first_tie: got g0g1=%b required 10", {obs_g0, obs_g1});
        end
    endtask

    task automatic test_stats();
        apply_reset();
        m0_req = 1; m1_req = 1;
        repeat (5) tick();
        m0_req = 0; m1_req = 0;
        tick();
        checks++;
        if (obs_stat !== 16'(exp_stat())) begin
            errors++; $display("FAIL stat_conflicts: got %0d required %0d", obs_stat, exp_stat());
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            tick();
            checks++;
            if (obs_g0 !== (exp_g == 1) || obs_g1 !== (exp_g == 2)) begin
                errors++; $display("FAIL rnd_gnt[%0d]: got g0g1=%b%b required grant %0d", c, obs_g0, obs_g1, exp_g);
            end
            checks++;
            if (obs_we !== exp_we || (exp_g != 0 && obs_addr !== exp_addr)) begin
                errors++; $display("FAIL rnd_mem[%0d]: we=%b addr=%0h required %b %0h", c, obs_we, obs_addr, exp_we, exp_addr);
            end
            checks++;
            if (obs_rv0 !== exp_rv0 || obs_rv1 !== exp_rv1 || obs_rd0 !== exp_rd0 || obs_rd1 !== exp_rd1) begin
                errors++; $display("FAIL rnd_read[%0d]: rv=%b%b rd0=%0h rd1=%0h required %b%b %0h %0h",
                                   c, obs_rv0, obs_rv1, obs_rd0, obs_rd1, exp_rv0, exp_rv1, exp_rd0, exp_rd1);
            end
            if (!m0_req || obs_g0) begin
                m0_req = ($urandom % 4) != 0; m0_we = $urandom % 2; m0_lock = ($urandom % 3) == 0;
                m0_addr = $urandom; m0_wdata = $urandom;
            end
            if (!m1_req || obs_g1) begin
                m1_req = ($urandom % 4) != 0; m1_we = $urandom % 2; m1_lock = ($urandom % 3) == 0;
                m1_addr = $urandom; m1_wdata = $urandom;
            end
        end
        tick();
        checks++;
        if (obs_stat !== 16'(exp_stat())) begin
            errors++; $display("FAIL rnd_stat: got %0d required %0d", obs_stat, exp_stat());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tie_reads();
        test_m1_write();
        test_lock();
        test_lock_drop();
        test_reset_mid();
        test_stats();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_dmem_arbiter.md
# sc_dmem_arbiter

Two-master arbiter that shares the single-port synchronous data memory (and its memory-mapped I/O window) between the single-cycle CPU and a second bus master, such as a debug/DMA engine that loads Hamming-distance operands. It sits between the masters and the data memory. It grants one access per cycle, uses round-robin fairness with bounded bus locking, and returns read data with a fixed one-cycle latency.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_LOCK`, 8, max consecutive grants one master may hold via lock (≥1)
- `clock` in 1: sole clock, rising edge
- `resetn` in 1: asynchronous, active-low reset
- `m0_req`, `m1_req` in 1: access request (held until granted)
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read
- `m0_lock`, `m1_lock` in 1: request to keep ownership for the next access
- `m0_addr`, `m1_addr` in AW: access address
- `m0_wdata`, `m1_wdata` in DW: write data
- `m0_gnt`, `m1_gnt` out 1: access accepted this cycle (combinational)
- `m0_rvalid`, `m1_rvalid` out 1: read data valid (registered)
- `m0_rdata`, `m1_rdata` out DW: read data
- `mem_addr` out AW, `mem_wdata` out DW, `mem_we` out 1: memory port
- `mem_rdata` in DW: memory read data, valid one cycle after address
- `stat_conflicts` out 16: contention counter (see Configuration)

## Operation
- Registered state: `last` (last-granted master), `owner`/`locked` (lock holder), `lock_cnt` (0..MAX_LOCK), `rv0`/`rv1` (read-valid pipeline).
- Grant decision, combinational, evaluated every cycle:
  - No request: no grant; `mem_we`=0; `mem_addr`/`mem_wdata` hold m0 values.
  - Exactly one master requests: that master is granted.
  - Both request, with `locked` and the owner requesting and `lock_cnt < MAX_LOCK`: the owner is granted.
  - Both request, otherwise: the master other than `last` is granted (round-robin).
- The granted master's addr/wdata/we are muxed to the memory port. `mem_we` = granted & we.
- Update on each grant:
  - `last` ← granted master.
  - If the granted master's lock=1: `locked`←1 and `owner`←granted. `lock_cnt` increments if the same owner was already locked; otherwise `lock_cnt`←1.
  - If lock=0: `locked`←0 and `lock_cnt`←0.
  - A forced handoff (lock held at `MAX_LOCK` while the other master requests) clears `locked` and grants the other master.
- A lock holder that drops `req` loses the lock immediately.
- Read return: `mN_rvalid` is 1 in the cycle after a granted read by master N. `mN_rdata` = `mem_rdata` in that cycle (passthrough). Otherwise `mN_rdata` = 0.
- A write completes in its grant cycle and produces no rvalid.
- A master must hold req/addr/we/wdata stable until it sees gnt. It may issue a new request in the cycle after gnt, back-to-back.

## Timing
- Reset values: `last`=1 (so m0 wins the first tie), `locked`=0, `lock_cnt`=0, `rv0`=`rv1`=0. All `gnt`/`rvalid` outputs are 0 and `stat_conflicts`=0.
- Grant latency is 0 cycles when uncontended. With round-robin, a waiting master is granted within 1 cycle. With locking, wait is ≤ `MAX_LOCK` cycles.
- Read latency is 1 cycle from gnt to rvalid. Throughput is 1 access/cycle.
- Only one `gnt` is high per cycle, and at most one `rvalid` is high per cycle.
- Reset asserted mid-operation clears pending rvalid immediately (asynchronous). A read granted in the cycle of reset returns no data.
- Simultaneous lock release and opposing request: normal round-robin applies in that same cycle.

## Configuration
- `DMEM_ARB_STATS_EN` defined: `stat_conflicts` counts cycles where both `req` are high.
  - The counter saturates at 16'hFFFF and is cleared by reset.
- `DMEM_ARB_STATS_EN` undefined: `stat_conflicts` is tied to 16'h0000 and no counter logic is built.

## Test plan
- After reset, assert m0 and m1 reads together, no lock → m0_gnt in cycle 0, m1_gnt in cycle 1. rvalid follows each grant one cycle later, with `mem_rdata` passed to the correct master.
- m1 alone writes addr 0x40, data 0xA5A5A5A5 → m1_gnt=1 and mem_we=1 in the same cycle, mem_addr=0x40, no m1_rvalid.
- Both request continuously, m0_lock=1, MAX_LOCK=8 → m0 receives 8 consecutive grants, then m1 is granted. Repeat the pattern and check no starvation.
- m0 locked, drops req for one cycle → m1 granted immediately, and m0 lock_cnt restarts at 1 on regrant.
- Assert resetn low in the cycle after a granted m0 read → m0_rvalid=0 immediately. After release, the first tie goes to m0.
- With `DMEM_ARB_STATS_EN`, 5 contention cycles → stat_conflicts=5. Without the macro → stat_conflicts stays 0.
